regfile_sb: RTL and testbench

- Parametrised multi-write-port register file with an integrated register scoreboard. It is the next-generation CPU register file.
- Two write ports: port A for ALU writeback, port B for load/long-latency writeback. Two combinational read ports with optional write-to-read bypass.
- Per-register busy bits track outstanding producers. The decode stage uses them to generate RAW stalls.

---
 rtl/regfile_sb.sv | 153 +++++++++++++++
 tb/tb_regfile_sb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module     : regfile_sb
// Description: Two-write/two-read register file with per-register busy
//              scoreboard and incremental busy counter.
// Revision   : 1.0 - initial release
// ============================================================================
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ra1_addr,
   input  logic [ADDR_W-1:0] ra2_addr,
   output logic [DATA_W-1:0] ra1_data,
   output logic [DATA_W-1:0] ra2_data,
   output logic              ra1_busy,
   output logic              ra2_busy,
   input  logic              wa_en,
   input  logic [ADDR_W-1:0] wa_addr,
   input  logic [DATA_W-1:0] wa_data,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr,
   input  logic              flush,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam int c_DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0]  r_mem [c_DEPTH];
   logic [c_DEPTH-1:0] r_busy;
   logic [ADDR_W:0]    r_busy_cnt;

   logic [c_DEPTH-1:0] w_hit_a;
   logic [c_DEPTH-1:0] w_hit_b;
   logic [c_DEPTH-1:0] w_busy_nxt;
   logic               w_iss_ok;
   logic               w_inc;
   logic               w_dec_a;
   logic               w_dec_b;
   logic [ADDR_W:0]    w_cnt_nxt;

   // Per-register write decode; register 0 is excluded when hardwired to zero
   genvar gi;
   generate
      for (gi = 0; gi < c_DEPTH; gi++) begin : g_dec
         if (ZERO_REG && gi == 0) begin : g_zero
            assign w_hit_a[gi] = 1'b0;
            assign w_hit_b[gi] = 1'b0;
         end else begin : g_norm
            assign w_hit_a[gi] = wa_en && (wa_addr == ADDR_W'(gi));
            assign w_hit_b[gi] = wb_en && (wb_addr == ADDR_W'(gi));
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < c_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < c_DEPTH; i++) begin
            if (w_hit_b[i]) begin
               r_mem[i] <= wb_data;
            end else if (w_hit_a[i]) begin
               r_mem[i] <= wa_data;
            end
         end
      end
   end

   assign w_iss_ok = iss_en && !(ZERO_REG && iss_addr == '0);

   always_comb begin
      w_busy_nxt = r_busy & ~(w_hit_a | w_hit_b);
      if (w_iss_ok) begin
         w_busy_nxt[iss_addr] = 1'b1;
      end
      if (flush) begin
         w_busy_nxt = '0;
      end
   end

   // A set can only land on iss_addr and clears only on the two write addresses,
   // so the count is tracked by edge deltas instead of a full popcount.
   assign w_inc   = w_iss_ok && !r_busy[iss_addr];
   assign w_dec_a = wa_en && r_busy[wa_addr] && !(w_iss_ok && iss_addr == wa_addr);
   assign w_dec_b = wb_en && r_busy[wb_addr] && !(w_iss_ok && iss_addr == wb_addr)
                    && !(wa_en && wa_addr == wb_addr);

   always_comb begin
      w_cnt_nxt = r_busy_cnt + (ADDR_W+1)'(w_inc)
                  - (ADDR_W+1)'(w_dec_a) - (ADDR_W+1)'(w_dec_b);
      if (flush) begin
         w_cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy     <= '0;
         r_busy_cnt <= '0;
      end else begin
         r_busy     <= w_busy_nxt;
         r_busy_cnt <= w_cnt_nxt;
      end
   end

   assign busy_cnt = r_busy_cnt;

   genvar gp;
   generate
      for (gp = 0; gp < 2; gp++) begin : g_rd
         logic [ADDR_W-1:0] w_addr;
         logic [DATA_W-1:0] w_data;
         logic              w_busy;

         assign w_addr = (gp == 0) ? ra1_addr : ra2_addr;

         always_comb begin
            w_data = r_mem[w_addr];
            w_busy = r_busy[w_addr];
            if (BYPASS) begin
               if (wb_en && wb_addr == w_addr) begin
                  w_data = wb_data;
                  w_busy = 1'b0;
               end else if (wa_en && wa_addr == w_addr) begin
                  w_data = wa_data;
                  w_busy = 1'b0;
               end
            end
            if (ZERO_REG && w_addr == '0) begin
               w_data = '0;
               w_busy = 1'b0;
            end
         end
      end
   endgenerate

   assign ra1_data = g_rd[0].w_data;
   assign ra2_data = g_rd[1].w_data;
   assign ra1_busy = g_rd[0].w_busy;
   assign ra2_busy = g_rd[1].w_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module     : tb_regfile_sb
// Description: Directed self-checking bench for regfile_sb with reference model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;

   logic              clk;
   logic              rst_n;
   logic [ADDR_W-1:0] ra1_addr, ra2_addr;
   logic [DATA_W-1:0] ra1_data, ra2_data;
   logic              ra1_busy, ra2_busy;
   logic              wa_en, wb_en, iss_en, flush;
   logic [ADDR_W-1:0] wa_addr, wb_addr, iss_addr;
   logic [DATA_W-1:0] wa_data, wb_data;
   logic [ADDR_W:0]   busy_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .ra1_addr(ra1_addr), .ra2_addr(ra2_addr),
      .ra1_data(ra1_data), .ra2_data(ra2_data),
      .ra1_busy(ra1_busy), .ra2_busy(ra2_busy),
      .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
      .busy_cnt(busy_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: architectural state only, count is a plain popcount
   logic [DATA_W-1:0] m_mem [DEPTH];
   logic [DEPTH-1:0]  m_busy;

   function automatic logic [DEPTH-1:0] next_busy();
      logic [DEPTH-1:0] nb;
      nb = m_busy;
      if (wa_en) nb[wa_addr] = 1'b0;
      if (wb_en) nb[wb_addr] = 1'b0;
      if (iss_en) nb[iss_addr] = 1'b1;
      if (flush) nb = '0;
      nb[0] = 1'b0;
      return nb;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
         m_busy <= '0;
      end else begin
         if (wa_en && wa_addr != 0) m_mem[wa_addr] <= wa_data;
         if (wb_en && wb_addr != 0) m_mem[wb_addr] <= wb_data;
         m_busy <= next_busy();
      end
   end

   function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a);
      if (a == 0) return '0;
      if (wb_en && wb_addr == a) return wb_data;
      if (wa_en && wa_addr == a) return wa_data;
      return m_mem[a];
   endfunction

   function automatic logic exp_busy(input logic [ADDR_W-1:0] a);
      if (a == 0) return 1'b0;
      if ((wb_en && wb_addr == a) || (wa_en && wa_addr == a)) return 1'b0;
      return m_busy[a];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en && rst_n) begin
         check("model ra1_data", 64'(ra1_data), 64'(exp_data(ra1_addr)));
         check("model ra2_data", 64'(ra2_data), 64'(exp_data(ra2_addr)));
         check("model ra1_busy", 64'(ra1_busy), 64'(exp_busy(ra1_addr)));
         check("model ra2_busy", 64'(ra2_busy), 64'(exp_busy(ra2_addr)));
         check("model busy_cnt", 64'(busy_cnt), 64'($countones(m_busy)));
      end
   end

   task automatic idle();
      wa_en = 0; wa_addr = '0; wa_data = '0;
      wb_en = 0; wb_addr = '0; wb_data = '0;
      iss_en = 0; iss_addr = '0; flush = 0;
      ra1_addr = '0; ra2_addr = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int r);
      idle(); iss_en = 1; iss_addr = ADDR_W'(r);
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      tick(); tick();
      @(negedge clk);
      check("reset busy_cnt", 64'(busy_cnt), 64'd0);
      check("reset ra1_data", 64'(ra1_data), 64'd0);
      tick();
      rst_n = 1'b1;
      cmp_en = 1'b1;

      // Zero register ignores writes and issues
      idle(); wa_en = 1; wa_addr = 0; wa_data = 32'hDEADBEEF; iss_en = 1; iss_addr = 0;
      @(negedge clk);
      check("r0 bypass data", 64'(ra1_data), 64'd0);
      check("r0 busy", 64'(ra1_busy), 64'd0);
      tick();
      idle();
      @(negedge clk);
      check("r0 stored data", 64'(ra1_data), 64'd0);
      check("r0 issue cnt", 64'(busy_cnt), 64'd0);
      tick();

      // Write with bypass
      idle(); wa_en = 1; wa_addr = 5; wa_data = 32'h12345678; ra1_addr = 5;
      @(negedge clk);
      check("r5 bypass", 64'(ra1_data), 64'h12345678);
      tick();
      idle(); ra1_addr = 5;
      @(negedge clk);
      check("r5 stored", 64'(ra1_data), 64'h12345678);
      tick();

      // Port collision: B wins
      idle(); wa_en = 1; wa_addr = 7; wa_data = 32'h1111;
      wb_en = 1; wb_addr = 7; wb_data = 32'h2222; ra1_addr = 7;
      @(negedge clk);
      check("r7 collide bypass", 64'(ra1_data), 64'h2222);
      tick();
      idle(); ra1_addr = 7;
      @(negedge clk);
      check("r7 collide stored", 64'(ra1_data), 64'h2222);
      tick();

      // Scoreboard lifecycle
      idle(); iss_en = 1; iss_addr = 3; ra2_addr = 3;
      @(negedge clk);
      check("iss same-cycle busy", 64'(ra2_busy), 64'd0);
      tick();
      issue(4);
      issue(9);
      idle(); ra2_addr = 4;
      @(negedge clk);
      check("cnt after 3 issues", 64'(busy_cnt), 64'd3);
      check("r4 busy", 64'(ra2_busy), 64'd1);
      tick();
      idle(); wb_en = 1; wb_addr = 4; wb_data = 32'h44; ra2_addr = 4;
      @(negedge clk);
      check("r4 wb bypass busy", 64'(ra2_busy), 64'd0);
      check("r4 wb bypass data", 64'(ra2_data), 64'h44);
      tick();
      idle(); ra2_addr = 4;
      @(negedge clk);
      check("cnt after wb clear", 64'(busy_cnt), 64'd2);
      tick();

      // Issue/write race on busy r3
      idle(); iss_en = 1; iss_addr = 3; wa_en = 1; wa_addr = 3; wa_data = 32'h33;
      tick();
      idle(); ra1_addr = 3;
      @(negedge clk);
      check("race r3 busy", 64'(ra1_busy), 64'd1);
      check("race cnt", 64'(busy_cnt), 64'd2);
      check("race r3 data", 64'(ra1_data), 64'h33);
      tick();

      // Two clears and one set in a single cycle
      issue(20);
      issue(21);
      idle(); wa_en = 1; wa_addr = 20; wa_data = 32'h20; wb_en = 1; wb_addr = 21;
      wb_data = 32'h21; iss_en = 1; iss_addr = 22;
      tick();
      idle(); ra1_addr = 22;
      @(negedge clk);
      check("dual clear cnt", 64'(busy_cnt), 64'd3);
      check("r22 busy", 64'(ra1_busy), 64'd1);
      tick();

      // Flush with concurrent issue and write (r3,r9,r22,r12,r13 busy)
      issue(12);
      issue(13);
      idle(); ra1_addr = 1;
      @(negedge clk);
      check("pre-flush cnt", 64'(busy_cnt), 64'd5);
      tick();
      idle(); flush = 1; iss_en = 1; iss_addr = 10; wb_en = 1; wb_addr = 11; wb_data = 32'hABCD;
      tick();
      idle(); ra1_addr = 11; ra2_addr = 10;
      @(negedge clk);
      check("flush cnt", 64'(busy_cnt), 64'd0);
      check("flush r11 data", 64'(ra1_data), 64'hABCD);
      check("flush r10 busy", 64'(ra2_busy), 64'd0);
      tick();

      // Fill every register: maximum count with the zero register
      for (int r = 0; r < DEPTH; r++) issue(r);
      idle();
      @(negedge clk);
      check("full cnt", 64'(busy_cnt), 64'd31);
      tick();
      issue(17);
      idle();
      @(negedge clk);
      check("re-issue busy cnt", 64'(busy_cnt), 64'd31);
      tick();
      idle(); flush = 1;
      tick();

      // Reset mid-operation drops that cycle's write and issue
      idle(); wa_en = 1; wa_addr = 5; wa_data = 32'h55; iss_en = 1; iss_addr = 6;
      rst_n = 1'b0;
      @(negedge clk);
      check("mid-reset cnt", 64'(busy_cnt), 64'd0);
      tick();
      rst_n = 1'b1;
      idle(); ra1_addr = 5; ra2_addr = 6;
      @(negedge clk);
      check("post-reset r5", 64'(ra1_data), 64'd0);
      check("post-reset r6 busy", 64'(ra2_busy), 64'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
